// File: rtl/hamming_accum.sv
// Bit-serial Hamming-distance accumulator: each XOR difference word is shifted out one bit
// per cycle and its set bits are summed into a saturating per-frame counter.
module hamming_accum #(
    parameter int N  = 16,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in_word,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [AW-1:0] out_count,
    output logic          out_ovf,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int              CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(N - 1);
    localparam logic [AW-1:0]   ACC_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  r_shreg;
    logic [CW-1:0] r_bitcnt;
    logic          r_last;
    logic [AW-1:0] r_acc;
    logic          r_ovf;
    logic          w_accept;
    logic          w_shift_done;
    logic          w_result;

    assign w_accept     = (r_state == IDLE) && in_valid;
    assign w_shift_done = (r_state == SHIFT) && (r_bitcnt == LAST_BIT);
    assign w_result     = (r_state == REPORT) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = SHIFT;
            SHIFT:   if (w_shift_done) w_next = r_last ? REPORT : IDLE;
            REPORT:  if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Shift register and bit counter only move while a word is being serialised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_last   <= 1'b0;
        end else if (w_accept) begin
            r_shreg  <= in_word;
            r_bitcnt <= '0;
            r_last   <= in_last;
        end else if (r_state == SHIFT) begin
            r_shreg  <= r_shreg >> 1;
            r_bitcnt <= r_bitcnt + CW'(1);
        end
    end

    // Accumulator spans all words of a frame; cleared only when the result is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_result) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if ((r_state == SHIFT) && r_shreg[0]) begin
            if (r_acc == ACC_MAX) r_ovf <= 1'b1;
            else                  r_acc <= r_acc + AW'(1);
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == REPORT);
    assign out_count = r_acc;
    assign out_ovf   = r_ovf;

endmodule
